// File: rtl/sme_param.sv
// sme_param: string matching engine. It loads a subject string, then matches patterns against it.
// Patterns may contain '.' (any char), a leading '^' and a trailing '$'.
module sme_param #(
  parameter int STR_MAX  = 32,
  parameter int PAT_MAX  = 8,
  parameter int FIND_ALL = 1,
  parameter int IDX_W    = $clog2(STR_MAX),
  parameter int CNT_W    = $clog2(STR_MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       chardata,
  input  logic             isstring,
  input  logic             ispattern,
  output logic             busy,
  output logic             valid,
  output logic             match,
  output logic [IDX_W-1:0] match_index,
  output logic [CNT_W-1:0] match_count
);

  localparam int LEN_W  = $clog2(STR_MAX + 1);
  localparam int PLEN_W = $clog2(PAT_MAX + 1);
  localparam int PIDX_W = $clog2(PAT_MAX);

  localparam logic [7:0] CARET  = 8'h5E;
  localparam logic [7:0] DOLLAR = 8'h24;
  localparam logic [7:0] DOT    = 8'h2E;
  localparam logic [7:0] SPACE  = 8'h20;

  typedef enum logic [2:0] {IDLE, LOAD_STR, LOAD_PAT, PREP, SEARCH, OUT} state_t;

  state_t            state;
  logic [7:0]        str_mem [STR_MAX];
  logic [7:0]        pat_mem [PAT_MAX];
  logic [7:0]        core    [PAT_MAX];
  logic [LEN_W-1:0]  str_len;
  logic [PLEN_W-1:0] pat_len;
  logic [PLEN_W-1:0] core_len;
  logic              as_flag;
  logic              ae_flag;
  logic [IDX_W-1:0]  pos;
  logic              found;
  logic [IDX_W-1:0]  first_idx;
  logic [CNT_W-1:0]  hit_cnt;

  function automatic logic [7:0] str_char(input int idx);
    if (idx >= 0 && idx < STR_MAX) return str_mem[idx[IDX_W-1:0]];
    return 8'h00;
  endfunction

  function automatic logic [7:0] pat_char(input int idx);
    if (idx >= 0 && idx < PAT_MAX) return pat_mem[idx[PIDX_W-1:0]];
    return 8'h00;
  endfunction

  // Anchor decode of the stored pattern; a lone '^' cannot double as the trailing '$'.
  logic              lead;
  logic              trail;
  logic [PLEN_W-1:0] core_len_nxt;

  always_comb begin
    lead         = (pat_len != '0) && (pat_mem[0] == CARET);
    trail        = (pat_len > PLEN_W'(lead)) && (pat_char(int'(pat_len) - 1) == DOLLAR);
    core_len_nxt = pat_len - PLEN_W'(lead) - PLEN_W'(trail);
  end

  // Parallel compare of the whole core against the window starting at pos.
  logic hit;

  always_comb begin
    hit = (int'(pos) + int'(core_len)) <= int'(str_len);
    for (int i = 0; i < PAT_MAX; i++) begin
      if (i < int'(core_len) && core[i] != DOT && core[i] != str_char(int'(pos) + i))
        hit = 1'b0;
    end
    if (as_flag && pos != '0 && str_char(int'(pos) - 1) != SPACE)
      hit = 1'b0;
    if (ae_flag && (int'(pos) + int'(core_len)) != int'(str_len) &&
        str_char(int'(pos) + int'(core_len)) != SPACE)
      hit = 1'b0;
  end

  logic             found_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             search_done;

  always_comb begin
    found_nxt   = found | hit;
    idx_nxt     = (!found && hit) ? pos : first_idx;
    cnt_nxt     = (hit && hit_cnt != '1) ? hit_cnt + 1'b1 : hit_cnt;
    search_done = (int'(pos) == int'(str_len) - 1) || (FIND_ALL == 0 && hit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      str_len     <= '0;
      pat_len     <= '0;
      core_len    <= '0;
      as_flag     <= 1'b0;
      ae_flag     <= 1'b0;
      pos         <= '0;
      found       <= 1'b0;
      first_idx   <= '0;
      hit_cnt     <= '0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      match       <= 1'b0;
      match_index <= '0;
      match_count <= '0;
    end else begin
      case (state)
        IDLE, LOAD_STR, LOAD_PAT: begin
          if (isstring && state != LOAD_PAT) begin
            if (state != LOAD_STR) begin
              str_mem[0] <= chardata;
              str_len    <= LEN_W'(1);
            end else if (int'(str_len) < STR_MAX) begin
              str_mem[str_len[IDX_W-1:0]] <= chardata;
              str_len <= str_len + 1'b1;
            end
            state <= LOAD_STR;
          end else if (ispattern) begin
            // In LOAD_PAT a concurrent isstring only discards this pattern char.
            if (!isstring) begin
              if (state != LOAD_PAT) begin
                pat_mem[0] <= chardata;
                pat_len    <= PLEN_W'(1);
              end else if (int'(pat_len) < PAT_MAX) begin
                pat_mem[pat_len[PIDX_W-1:0]] <= chardata;
                pat_len <= pat_len + 1'b1;
              end
            end
            state <= LOAD_PAT;
          end else if (state == LOAD_PAT) begin
            state <= PREP;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        PREP: begin
          as_flag   <= lead;
          ae_flag   <= trail;
          core_len  <= core_len_nxt;
          pos       <= '0;
          found     <= 1'b0;
          first_idx <= '0;
          hit_cnt   <= '0;
          for (int i = 0; i < PAT_MAX; i++)
            core[i] <= pat_char(i + int'(lead));
          if (str_len == '0 || core_len_nxt == '0 || int'(core_len_nxt) > int'(str_len))
            state <= OUT;
          else
            state <= SEARCH;
        end

        SEARCH: begin
          found     <= found_nxt;
          first_idx <= idx_nxt;
          hit_cnt   <= cnt_nxt;
          if (search_done) begin
            valid       <= 1'b1;
            match       <= found_nxt;
            match_index <= idx_nxt;
            match_count <= cnt_nxt;
            state       <= OUT;
          end else begin
            pos <= pos + 1'b1;
          end
        end

        OUT: begin
          // Entered with valid low only on the early no-match path from PREP.
          if (!valid) begin
            valid       <= 1'b1;
            match       <= found;
            match_index <= first_idx;
            match_count <= hit_cnt;
          end else begin
            valid <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sme_param.sv
// Bench for sme_param: drives FIND_ALL=1 and FIND_ALL=0 instances with the same stimulus.
// Both are checked against a string-level reference model.
module tb_sme_param;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int IDX_W   = 5;
  localparam int CNT_W   = 6;

  logic clk = 1'b0;
  logic reset;
  logic [7:0] chardata;
  logic isstring, ispattern;

  logic             busy_a, valid_a, match_a;
  logic [IDX_W-1:0] idx_a;
  logic [CNT_W-1:0] cnt_a;
  logic             busy_f, valid_f, match_f;
  logic [IDX_W-1:0] idx_f;
  logic [CNT_W-1:0] cnt_f;

  always #5 clk = ~clk;

  sme_param #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .FIND_ALL(1)) u_all (
    .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .busy(busy_a), .valid(valid_a), .match(match_a), .match_index(idx_a), .match_count(cnt_a));

  sme_param #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .FIND_ALL(0)) u_first (
    .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .busy(busy_f), .valid(valid_f), .match(match_f), .match_index(idx_f), .match_count(cnt_f));

  int n_checks = 0;
  int n_errors = 0;
  string model_str = "";

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: evaluate every start position directly from the matching rules.
  function automatic void ref_model(input string s, input string pin, input bit find_all,
                                    output int m, output int idx, output int cnt, output int lat);
    string pt;
    int n, plen, as, ae, l;
    bit ok;
    pt = (pin.len() > PAT_MAX) ? pin.substr(0, PAT_MAX - 1) : pin;
    n = s.len();
    plen = pt.len();
    as = (plen > 0 && pt[0] == 8'h5E) ? 1 : 0;
    ae = (plen > as && pt[plen-1] == 8'h24) ? 1 : 0;
    l = plen - as - ae;
    m = 0; idx = 0; cnt = 0; lat = 2;
    if (n == 0 || l == 0 || l > n) return;
    lat = n + 1;
    for (int p = 0; p + l <= n; p++) begin
      ok = 1;
      for (int i = 0; i < l; i++)
        if (pt[as+i] != 8'h2E && pt[as+i] != s[p+i]) ok = 0;
      if (as == 1 && p != 0 && s[p-1] != 8'h20) ok = 0;
      if (ae == 1 && p + l != n && s[p+l] != 8'h20) ok = 0;
      if (ok) begin
        if (m == 0) idx = p;
        m = 1;
        cnt++;
        if (!find_all) begin
          lat = p + 2;
          return;
        end
      end
    end
  endfunction

  task automatic send_string(input string s);
    for (int i = 0; i < s.len(); i++) begin
      isstring = 1'b1;
      chardata = s[i];
      @(posedge clk); #1;
    end
    isstring = 1'b0;
    model_str = (s.len() > STR_MAX) ? s.substr(0, STR_MAX - 1) : s;
    @(posedge clk); #1;
  endtask

  // Returns just after edge k, the edge that samples the pattern's end.
  task automatic send_pattern(input string s);
    for (int i = 0; i < s.len(); i++) begin
      ispattern = 1'b1;
      chardata = s[i];
      @(posedge clk); #1;
    end
    ispattern = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_pattern(input string tag, input string pt);
    int em[2], ei[2], ec[2], el[2];
    int gm[2], gi[2], gc[2], gl[2];
    logic v[2], b[2];
    ref_model(model_str, pt, 1'b1, em[0], ei[0], ec[0], el[0]);
    ref_model(model_str, pt, 1'b0, em[1], ei[1], ec[1], el[1]);
    send_pattern(pt);
    check({tag, " busy_all"}, int'(busy_a), 1);
    check({tag, " busy_first"}, int'(busy_f), 1);
    gl[0] = -1; gl[1] = -1;
    gm[0] = 0; gi[0] = 0; gc[0] = 0;
    gm[1] = 0; gi[1] = 0; gc[1] = 0;
    for (int cyc = 1; cyc <= STR_MAX + 10; cyc++) begin
      @(posedge clk); #1;
      v[0] = valid_a; b[0] = busy_a;
      v[1] = valid_f; b[1] = busy_f;
      for (int j = 0; j < 2; j++) begin
        if (gl[j] >= 0 && gl[j] == cyc - 1)
          check({tag, j == 0 ? " post_all" : " post_first"}, int'({v[j], b[j]}), 0);
        if (gl[j] < 0 && v[j]) begin
          gl[j] = cyc;
          gm[j] = (j == 0) ? int'(match_a) : int'(match_f);
          gi[j] = (j == 0) ? int'(idx_a) : int'(idx_f);
          gc[j] = (j == 0) ? int'(cnt_a) : int'(cnt_f);
        end
      end
      if (gl[0] >= 0 && gl[1] >= 0 && cyc > gl[0] && cyc > gl[1]) break;
    end
    for (int j = 0; j < 2; j++) begin
      string sfx;
      sfx = (j == 0) ? "_all" : "_first";
      check({tag, " latency", sfx}, gl[j], el[j]);
      check({tag, " match", sfx}, gm[j], em[j]);
      check({tag, " index", sfx}, gi[j], ei[j]);
      check({tag, " count", sfx}, gc[j], ec[j]);
    end
  endtask

  function automatic string rand_text(input string alpha, input int len);
    string s;
    int k;
    s = "";
    for (int i = 0; i < len; i++) begin
      k = $urandom_range(alpha.len() - 1);
      s = {s, alpha.substr(k, k)};
    end
    return s;
  endfunction

  initial begin
    reset = 1'b1; isstring = 1'b0; ispattern = 1'b0; chardata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset outs_all", int'({busy_a, valid_a, match_a, idx_a, cnt_a}), 0);
    check("reset outs_first", int'({busy_f, valid_f, match_f, idx_f, cnt_f}), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    send_string("this is a book");
    run_pattern("is", "is");
    run_pattern("caret_is", "^is");
    run_pattern("caret_th", "^th");
    run_pattern("ok_dollar", "ok$");
    run_pattern("dots", "b..k");
    run_pattern("xyz", "xyz");
    run_pattern("anchors_only", "^$");
    run_pattern("pat_overflow", "s is a bXY");

    send_string("abcdefghijklmnopqrstuvwxyz012345XYZ");
    run_pattern("str_overflow", "45$");
    run_pattern("str_dropped", "XY");

    send_string("abc");
    run_pattern("pat_longer", "abcd");

    send_string("aaaa");
    run_pattern("aa", "aa");
    run_pattern("a_dollar", "a$");

    // Reset in the middle of a search, then search with no string loaded.
    send_string("this is a book");
    send_pattern("ok");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("midreset outs_all", int'({busy_a, valid_a, match_a, idx_a, cnt_a}), 0);
    check("midreset outs_first", int'({busy_f, valid_f, match_f, idx_f, cnt_f}), 0);
    reset = 1'b0;
    model_str = "";
    @(posedge clk); #1;
    run_pattern("no_string", "is");

    for (int it = 0; it < 40; it++) begin
      if (it == 0 || $urandom_range(2) == 0)
        send_string(rand_text("ab .", $urandom_range(STR_MAX + 3, 1)));
      run_pattern($sformatf("rand%0d", it), rand_text("ab .^$", $urandom_range(PAT_MAX + 2, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
